// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed RX front end: pin sync, bit-timing recovery, NRZI decode, bit unstuffing.
// Optional `EDGE_RESYNC_EN: every line transition in ACTIVE/EOP_WAIT realigns the bit timer.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       d_sent,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       eop,
  output logic       stuff_err,
  output logic       rx_active,
  output logic [1:0] o_dbg_state
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [TW-1:0] L_TMAX   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] L_SAMPLE = TW'(SAMPLE_PHASE);
  localparam logic [TW-1:0] L_TONE   = TW'(1);
  localparam logic [OW-1:0] L_STUFF  = OW'(STUFF_LEN);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_EOP_WAIT = 2'd2
  } state_t;

  logic          r_dp_meta, r_dp_s, r_dm_meta, r_dm_s, r_dp_d;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_prev, w_prev_nxt, w_prev_cur;
  logic [OW-1:0] r_ones, w_ones_nxt, w_ones_cur;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt, w_bitcnt_cur;
  logic          r_rx_active, w_rx_active_nxt;
  logic          r_byte_received, w_br_nxt;
  logic          w_edge, w_sample, w_se0, w_j, w_k;
  logic          w_decode, w_restart, w_bit, w_shift, w_eop, w_stuff_err;

  assign w_edge   = (r_dp_s != r_dp_d);
  assign w_sample = (r_state != ST_IDLE) && (r_timer == L_SAMPLE);
  assign w_se0    = !r_dp_s && !r_dm_s;
  assign w_j      =  r_dp_s && !r_dm_s;
  assign w_k      = !r_dp_s &&  r_dm_s;

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_prev_nxt      = r_prev;
    w_ones_nxt      = r_ones;
    w_bitcnt_nxt    = r_bitcnt;
    w_rx_active_nxt = r_rx_active;
    w_br_nxt        = 1'b0;
    w_decode        = 1'b0;
    w_restart       = 1'b0;
    w_bit           = 1'b0;
    w_shift         = 1'b0;
    w_eop           = 1'b0;
    w_stuff_err     = 1'b0;

    if (r_state != ST_IDLE) begin
      w_timer_nxt = (r_timer == L_TMAX) ? '0 : r_timer + L_TONE;
`ifdef EDGE_RESYNC_EN
      if (w_edge) w_timer_nxt = L_TONE;
`endif
    end

    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_edge && !r_dp_s) begin
          w_state_nxt     = ST_ACTIVE;
          w_rx_active_nxt = 1'b1;
          w_bitcnt_nxt    = '0;
          w_ones_nxt      = '0;
          w_prev_nxt      = 1'b1;
          w_timer_nxt     = L_TONE;
        end
      end
      ST_ACTIVE: begin
        if (w_sample) begin
          if (w_se0) begin
            w_eop        = 1'b1;
            w_bitcnt_nxt = '0;
            w_state_nxt  = ST_EOP_WAIT;
          end else begin
            w_decode = 1'b1;
          end
        end
      end
      ST_EOP_WAIT: begin
        if (w_sample) begin
          if (w_j) begin
            w_state_nxt     = ST_IDLE;
            w_rx_active_nxt = 1'b0;
            w_timer_nxt     = '0;
          end else if (w_k) begin
            // A K here opens a new packet; decode it against a fresh J reference.
            w_state_nxt = ST_ACTIVE;
            w_decode    = 1'b1;
            w_restart   = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_prev_cur   = w_restart ? 1'b1 : r_prev;
    w_ones_cur   = w_restart ? '0   : r_ones;
    w_bitcnt_cur = w_restart ? '0   : r_bitcnt;

    if (w_decode) begin
      w_bit      = (r_dp_s == w_prev_cur);
      w_prev_nxt = r_dp_s;
      if (w_ones_cur == L_STUFF) begin
        // Stuffed position: a 0 is expected and discarded; a 1 is a violation.
        w_ones_nxt  = '0;
        w_stuff_err = w_bit;
      end else begin
        w_shift      = 1'b1;
        w_ones_nxt   = w_bit ? w_ones_cur + 1'b1 : '0;
        w_bitcnt_nxt = w_bitcnt_cur + 3'd1;
        w_br_nxt     = (w_bitcnt_cur == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_meta       <= 1'b1;
      r_dp_s          <= 1'b1;
      r_dm_meta       <= 1'b0;
      r_dm_s          <= 1'b0;
      r_dp_d          <= 1'b1;
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_prev          <= 1'b1;
      r_ones          <= '0;
      r_bitcnt        <= '0;
      r_rx_active     <= 1'b0;
      r_byte_received <= 1'b0;
    end else begin
      r_dp_meta       <= d_plus;
      r_dp_s          <= r_dp_meta;
      r_dm_meta       <= d_minus;
      r_dm_s          <= r_dm_meta;
      r_dp_d          <= r_dp_s;
      r_state         <= w_state_nxt;
      r_timer         <= w_timer_nxt;
      r_prev          <= w_prev_nxt;
      r_ones          <= w_ones_nxt;
      r_bitcnt        <= w_bitcnt_nxt;
      r_rx_active     <= w_rx_active_nxt;
      r_byte_received <= w_br_nxt;
    end
  end

  assign d_sent        = w_shift & w_bit;
  assign shift_enable  = w_shift;
  assign eop           = w_eop;
  assign stuff_err     = w_stuff_err;
  assign byte_received = r_byte_received;
  assign rx_active     = r_rx_active;
  assign o_dbg_state   = r_state;

endmodule
